// File: rtl/conv_out_quant_if.sv
// Stream bundle between a convolution PE, the output quantiser and its consumer.
// The input side has no back-pressure. The output side uses valid/ready: a beat transfers on a
// rising edge where o_valid && i_ready, and o_data plus its tags hold stable while o_valid && !i_ready.
interface conv_out_quant_if #(
  parameter int OUT_WIDTH = 16
);
  logic                        i_en;
  logic                        i_valid;
  logic signed [47:0]          i_P;
  logic                        i_ready;
  logic                        o_valid;
  logic signed [OUT_WIDTH-1:0] o_data;
  logic                        o_last_col;
  logic                        o_last_frame;

  modport slave (
    input  i_en, i_valid, i_P, i_ready,
    output o_valid, o_data, o_last_col, o_last_frame
  );

  modport master (
    output i_en, i_valid, i_P, i_ready,
    input  o_valid, o_data, o_last_col, o_last_frame
  );
endinterface

// File: rtl/conv_out_quant.sv
// Quantises 48-bit PE accumulator results (round, shift, ReLU, saturate), tags row/frame ends,
// and buffers the pixels in a first-word-fall-through FIFO.
module conv_out_quant #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 5,
  parameter int STRIDE      = 1,
  parameter int SHIFT       = 4,
  parameter int OUT_WIDTH   = 16,
  parameter int RELU        = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  conv_out_quant_if.slave      io_bus,
  output logic                 o_frame_done,
  output logic                 o_overflow
);
  localparam int OUT_SIZE = (FM_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int CW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int EW       = OUT_WIDTH + 2;
  localparam logic [CW-1:0]     LAST_IDX = CW'(OUT_SIZE - 1);
  localparam logic [AW:0]       FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [47:0] RND     = (SHIFT > 0) ? (48'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 48'sd0;
  localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (OUT_WIDTH - 1)) - 48'sd1;
  localparam logic signed [47:0] SAT_MIN = -(48'sd1 <<< (OUT_WIDTH - 1));

  logic                        w_accept, w_tag_lc, w_tag_lf;
  logic signed [47:0]          w_sum, w_shifted;
  logic signed [OUT_WIDTH-1:0] w_q;
  logic                        w_full, w_empty, w_pop, w_wr, w_drop;
  logic [EW-1:0]               w_head;

  logic [CW-1:0]               r_col, r_row;
  logic                        r_s1_v, r_s1_lc, r_s1_lf;
  logic signed [47:0]          r_s1_data;
  logic                        r_s2_v, r_s2_lc, r_s2_lf;
  logic signed [OUT_WIDTH-1:0] r_s2_data;
  logic [EW-1:0]               r_mem [FIFO_DEPTH];
  logic [AW-1:0]               r_wr_ptr, r_rd_ptr;
  logic [AW:0]                 r_count;
  logic                        r_frame_done, r_overflow;

  assign w_accept  = io_bus.i_en & io_bus.i_valid;
  assign w_tag_lc  = (r_col == LAST_IDX);
  assign w_tag_lf  = w_tag_lc && (r_row == LAST_IDX);
  assign w_sum     = io_bus.i_P + RND;
  assign w_shifted = w_sum >>> SHIFT;

  // Pixel position; a sample past the last pixel simply wraps into the next frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (!io_bus.i_en) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_tag_lc) begin
        r_col <= '0;
        r_row <= w_tag_lf ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_comb begin
    w_q = r_s1_data[OUT_WIDTH-1:0];
    if (RELU != 0 && r_s1_data < 0) w_q = '0;
    else if (r_s1_data > SAT_MAX)   w_q = SAT_MAX[OUT_WIDTH-1:0];
    else if (r_s1_data < SAT_MIN)   w_q = SAT_MIN[OUT_WIDTH-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_lc   <= 1'b0;
      r_s1_lf   <= 1'b0;
      r_s1_data <= '0;
      r_s2_v    <= 1'b0;
      r_s2_lc   <= 1'b0;
      r_s2_lf   <= 1'b0;
      r_s2_data <= '0;
    end else begin
      r_s1_v <= w_accept;
      r_s2_v <= io_bus.i_en & r_s1_v;
      if (w_accept) begin
        r_s1_data <= w_shifted;
        r_s1_lc   <= w_tag_lc;
        r_s1_lf   <= w_tag_lf;
      end
      if (r_s1_v) begin
        r_s2_data <= w_q;
        r_s2_lc   <= r_s1_lc;
        r_s2_lf   <= r_s1_lf;
      end
    end
  end

  // A write into a full FIFO still lands when the head is popped on the same edge.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty & io_bus.i_ready;
  assign w_wr    = r_s2_v & (!w_full | w_pop);
  assign w_drop  = r_s2_v & w_full & !w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_s2_lf, r_s2_lc, r_s2_data};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_frame_done <= w_pop & w_head[EW-1];
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Masking the head keeps the outputs at zero while the FIFO is empty or in reset.
  assign io_bus.o_valid      = !w_empty;
  assign io_bus.o_data       = w_empty ? '0 : w_head[OUT_WIDTH-1:0];
  assign io_bus.o_last_col   = w_empty ? 1'b0 : w_head[EW-2];
  assign io_bus.o_last_frame = w_empty ? 1'b0 : w_head[EW-1];
  assign o_frame_done        = r_frame_done;
  assign o_overflow          = r_overflow;
endmodule

// File: tb/tb_conv_out_quant.sv
// Directed bench for conv_out_quant: dut_a uses SHIFT=4/RELU=1/FIFO_DEPTH=4,
// dut_b uses SHIFT=0/RELU=0 for the signed saturation cases.
module tb_conv_out_quant;
  logic clk = 1'b0;
  logic rst_n;
  logic fd_a, ovf_a, fd_b, ovf_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  conv_out_quant_if #(.OUT_WIDTH(16)) bus_a ();
  conv_out_quant_if #(.OUT_WIDTH(16)) bus_b ();

  conv_out_quant #(.KERNEL_SIZE(3), .FM_SIZE(5), .STRIDE(1), .SHIFT(4), .OUT_WIDTH(16),
                   .RELU(1), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_a), .o_frame_done(fd_a), .o_overflow(ovf_a)
  );

  conv_out_quant #(.KERNEL_SIZE(3), .FM_SIZE(5), .STRIDE(1), .SHIFT(0), .OUT_WIDTH(16),
                   .RELU(0), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus_b), .o_frame_done(fd_b), .o_overflow(ovf_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus_a.o_valid); end
    n_checks++; if (bus_a.o_data !== 16'sd0) begin n_fail++; $display("FAIL reset_data got %0d exp 0", bus_a.o_data); end
    n_checks++; if (bus_a.o_last_col !== 1'b0) begin n_fail++; $display("FAIL reset_last_col got %b exp 0", bus_a.o_last_col); end
    n_checks++; if (bus_a.o_last_frame !== 1'b0) begin n_fail++; $display("FAIL reset_last_frame got %b exp 0", bus_a.o_last_frame); end
    n_checks++; if (fd_a !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b exp 0", fd_a); end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", ovf_a); end
    n_checks++; if (bus_b.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got %b exp 0", bus_b.o_valid); end
    n_checks++; if (fd_b !== 1'b0) begin n_fail++; $display("FAIL reset_b_frame_done got %b exp 0", fd_b); end
  endtask

  task automatic test_quant();
    logic signed [47:0] qp [4] = '{48'sd37, 48'sd40, -48'sd100, 48'sd1073741824};
    logic signed [15:0] qe [4] = '{16'sd2, 16'sd3, 16'sd0, 16'sd32767};
    bus_a.i_en = 1'b1; bus_a.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_a.i_valid = 1'b1; bus_a.i_P = qp[i];
      step();
      bus_a.i_valid = 1'b0;
      n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL quant_early1[%0d] got %b exp 0", i, bus_a.o_valid); end
      step();
      n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL quant_early2[%0d] got %b exp 0", i, bus_a.o_valid); end
      step();
      n_checks++; if (bus_a.o_valid !== 1'b1) begin n_fail++; $display("FAIL quant_valid[%0d] got %b exp 1", i, bus_a.o_valid); end
      n_checks++; if (bus_a.o_data !== qe[i]) begin n_fail++; $display("FAIL quant_data[%0d] got %0d exp %0d", i, bus_a.o_data, qe[i]); end
      step();
      n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL quant_popped[%0d] got %b exp 0", i, bus_a.o_valid); end
    end
    bus_a.i_en = 1'b0;
    step();
  endtask

  task automatic test_no_relu();
    logic signed [47:0] qp [4] = '{-48'sd1099511627776, -48'sd5, 48'sd40000, 48'sd12345};
    logic signed [15:0] qe [4] = '{-16'sd32768, -16'sd5, 16'sd32767, 16'sd12345};
    bus_b.i_en = 1'b1; bus_b.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_b.i_valid = 1'b1; bus_b.i_P = qp[i];
      step();
      bus_b.i_valid = 1'b0;
      step();
      step();
      n_checks++; if (bus_b.o_valid !== 1'b1) begin n_fail++; $display("FAIL norelu_valid[%0d] got %b exp 1", i, bus_b.o_valid); end
      n_checks++; if (bus_b.o_data !== qe[i]) begin n_fail++; $display("FAIL norelu_data[%0d] got %0d exp %0d", i, bus_b.o_data, qe[i]); end
      step();
    end
    n_checks++; if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL norelu_overflow got %b exp 0", ovf_b); end
    bus_b.i_en = 1'b0;
  endtask

  // Streams n back-to-back samples (pixel k quantises to k) and checks order, tags and frame_done.
  task automatic test_frame(input int n);
    int   got = 0;
    int   fd_n = 0;
    logic fd_exp;
    logic lc_exp, lf_exp;
    bus_a.i_en = 1'b1; bus_a.i_ready = 1'b1;
    for (int c = 0; c < n + 10; c++) begin
      bus_a.i_valid = (c < n);
      bus_a.i_P = 48'(16 * (c + 1));
      fd_exp = 1'b0;
      if (bus_a.o_valid) begin
        lc_exp = ((got % 3) == 2);
        lf_exp = ((got % 9) == 8);
        n_checks++; if (bus_a.o_data !== 16'(got + 1)) begin n_fail++; $display("FAIL frame_data[%0d] got %0d exp %0d", got, bus_a.o_data, got + 1); end
        n_checks++; if (bus_a.o_last_col !== lc_exp) begin n_fail++; $display("FAIL frame_last_col[%0d] got %b exp %b", got, bus_a.o_last_col, lc_exp); end
        n_checks++; if (bus_a.o_last_frame !== lf_exp) begin n_fail++; $display("FAIL frame_last_frame[%0d] got %b exp %b", got, bus_a.o_last_frame, lf_exp); end
        fd_exp = lf_exp;
        got++;
      end
      step();
      n_checks++; if (fd_a !== fd_exp) begin n_fail++; $display("FAIL frame_done_cycle[%0d] got %b exp %b", c, fd_a, fd_exp); end
      if (fd_a) fd_n++;
    end
    n_checks++; if (got != n) begin n_fail++; $display("FAIL frame_count got %0d exp %0d", got, n); end
    n_checks++; if (fd_n != 1) begin n_fail++; $display("FAIL frame_done_pulses got %0d exp 1", fd_n); end
  endtask

  task automatic test_tags();
    bus_a.i_en = 1'b0;
    step();
    test_frame(10);
  endtask

  task automatic test_overflow();
    bus_a.i_en = 1'b0;
    step();
    bus_a.i_en = 1'b1; bus_a.i_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus_a.i_valid = 1'b1; bus_a.i_P = 48'(16 * k);
      step();
    end
    bus_a.i_valid = 1'b0;
    step();
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ovf_full_no_drop got %b exp 0", ovf_a); end
    step();
    step();
    n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", ovf_a); end
    n_checks++; if (bus_a.o_data !== 16'sd1) begin n_fail++; $display("FAIL ovf_hold1 got %0d exp 1", bus_a.o_data); end
    step();
    n_checks++; if (bus_a.o_data !== 16'sd1) begin n_fail++; $display("FAIL ovf_hold2 got %0d exp 1", bus_a.o_data); end
    bus_a.i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (bus_a.o_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_pop_valid[%0d] got %b exp 1", k, bus_a.o_valid); end
      n_checks++; if (bus_a.o_data !== 16'(k)) begin n_fail++; $display("FAIL ovf_pop_data[%0d] got %0d exp %0d", k, bus_a.o_data, k); end
      step();
    end
    n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got %b exp 0", bus_a.o_valid); end
    n_checks++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", ovf_a); end
  endtask

  task automatic test_back_to_back();
    int exp_k = 1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL b2b_reset_ovf got %b exp 0", ovf_a); end
    step();
    rst_n = 1'b1;
    bus_a.i_en = 1'b1; bus_a.i_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bus_a.i_valid = 1'b1; bus_a.i_P = 48'(16 * k);
      step();
    end
    bus_a.i_valid = 1'b0; bus_a.i_ready = 1'b1;
    n_checks++; if (bus_a.o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_full_valid got %b exp 1", bus_a.o_valid); end
    for (int c = 0; c < 15; c++) begin
      if (bus_a.o_valid) begin
        n_checks++; if (bus_a.o_data !== 16'(exp_k)) begin n_fail++; $display("FAIL b2b_data[%0d] got %0d exp %0d", exp_k, bus_a.o_data, exp_k); end
        exp_k++;
      end
      step();
    end
    n_checks++; if (exp_k != 7) begin n_fail++; $display("FAIL b2b_count got %0d exp 6", exp_k - 1); end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %b exp 0", ovf_a); end
  endtask

  task automatic test_reset_mid_frame();
    bus_a.i_en = 1'b1; bus_a.i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bus_a.i_valid = 1'b1; bus_a.i_P = 48'(16 * k);
      step();
    end
    bus_a.i_valid = 1'b0;
    step();
    step();
    n_checks++; if (bus_a.o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b exp 1", bus_a.o_valid); end
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", bus_a.o_valid); end
    n_checks++; if (bus_a.o_data !== 16'sd0) begin n_fail++; $display("FAIL mid_data got %0d exp 0", bus_a.o_data); end
    n_checks++; if (bus_a.o_last_col !== 1'b0) begin n_fail++; $display("FAIL mid_last_col got %b exp 0", bus_a.o_last_col); end
    n_checks++; if (bus_a.o_last_frame !== 1'b0) begin n_fail++; $display("FAIL mid_last_frame got %b exp 0", bus_a.o_last_frame); end
    step();
    rst_n = 1'b1;
    bus_a.i_ready = 1'b1;
    step();
    step();
    step();
    n_checks++; if (bus_a.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discarded got %b exp 0", bus_a.o_valid); end
    test_frame(9);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.i_en = 1'b0; bus_a.i_valid = 1'b0; bus_a.i_P = '0; bus_a.i_ready = 1'b1;
    bus_b.i_en = 1'b0; bus_b.i_valid = 1'b0; bus_b.i_P = '0; bus_b.i_ready = 1'b1;
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_quant();
    test_no_relu();
    test_tags();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
